// File: rtl/lane_serializer.sv
// Replays one wide FIFO row (RP lanes of DW bits) as a lane-0-first valid/ready stream.
// The next row is popped in the same cycle the last lane is accepted, so rows stream without bubbles.
module lane_serializer #(
  parameter int DW = 64,
  parameter int RP = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [DW*RP-1:0] data_r,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last
);

  localparam int CW = (RP > 1) ? $clog2(RP) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RP - 1);

  logic [DW*RP-1:0] row_reg, row_next;
  logic             buf_valid_reg, buf_valid_next;
  logic [CW-1:0]    idx_reg, idx_next;

  logic             accept;
  logic             is_last;
  logic             final_accept;
  logic [DW-1:0]    lanes [RP];
  logic [DW-1:0]    lane_sel;

  for (genvar gi = 0; gi < RP; gi++) begin : g_lane
    assign lanes[gi] = row_reg[DW*gi +: DW];
  end

  assign accept       = buf_valid_reg & out_ready;
  assign is_last      = (idx_reg == LAST_IDX);
  assign final_accept = accept & is_last;

  // Flush wins even over a final accept, so no row is taken in the flush cycle.
  assign fifo_pop = ~flush & ~fifo_empty & (~buf_valid_reg | final_accept);

  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < RP; k++) begin
      if (idx_reg == CW'(k)) lane_sel = lanes[k];
    end
  end

  assign out_valid = buf_valid_reg;
  assign out_data  = buf_valid_reg ? lane_sel : '0;
  assign out_last  = buf_valid_reg & is_last;

  always_comb begin
    row_next       = row_reg;
    buf_valid_next = buf_valid_reg;
    idx_next       = idx_reg;
    if (flush) begin
      buf_valid_next = 1'b0;
      idx_next       = '0;
    end else if (fifo_pop) begin
      row_next       = data_r;
      buf_valid_next = 1'b1;
      idx_next       = '0;
    end else if (final_accept) begin
      buf_valid_next = 1'b0;
      idx_next       = '0;
    end else if (accept) begin
      idx_next = idx_reg + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_reg       <= '0;
      buf_valid_reg <= 1'b0;
      idx_reg       <= '0;
    end else begin
      row_reg       <= row_next;
      buf_valid_reg <= buf_valid_next;
      idx_reg       <= idx_next;
    end
  end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of the asymmetric multi-lane FIFO.
- Pops one RP-lane row (DW*RP bits) from the FIFO head and replays it as single DW-bit lanes on a valid/ready stream, lane 0 first.
- Gives scalar consumers (trace checkers, memory/bus models in the testbench) a one-word-per-cycle view of wide FIFO rows.
- Full throughput: the next row is popped in the same cycle the last lane of the current row is accepted.

Parameters:
- DW, 64, width of one lane in bits.
- RP, 4, lanes per FIFO row; must match the FIFO read-port count; RP >= 1.
- CW, $clog2(RP) (min 1), lane index width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of the held row; same flush net that drives the FIFO.
- fifo_empty  input  1  FIFO has no complete RP-lane row available.
- data_r  input  DW*RP  FIFO head row, first-word-fall-through; lane k at bits [DW*k +: DW].
- fifo_pop  output  1  pop request to the FIFO.
- out_valid  output  1  out_data holds a valid lane.
- out_ready  input  1  downstream accepts a lane when high together with out_valid.
- out_data  output  DW  current lane of the held row.
- out_last  output  1  current lane is lane RP-1 of its row.

Behaviour:
- State registers:
  - buf: DW*RP-bit holding register.
  - buf_valid: 1 bit.
  - idx: CW-bit lane index.
- Reset (RSTn low, asynchronous):
  - buf_valid=0, idx=0, buf=0.
  - Hence out_valid=0, out_last=0, out_data=0.
  - fifo_pop=0, because the FIFO is held empty by its own reset.
- Definitions:
  - accept = out_valid & out_ready.
  - final = accept & (idx == RP-1).
- fifo_pop = ~flush & ~fifo_empty & (~buf_valid | final). Combinational; never asserted while fifo_empty=1.
- On fifo_pop:
  - buf <= data_r, buf_valid <= 1, idx <= 0.
  - Lane 0 appears on out_data the next cycle (pop-to-first-lane latency 1 cycle).
- On accept with idx != RP-1:
  - idx <= idx+1.
  - buf and buf_valid unchanged.
- On final without fifo_pop:
  - buf_valid <= 0, idx <= 0.
  - out_valid drops the next cycle.
- On final with fifo_pop:
  - Reload buf from data_r, idx <= 0, buf_valid stays 1.
  - No bubble between rows.
- Outputs:
  - out_valid = buf_valid.
  - out_data = buf[DW*idx +: DW] when buf_valid, else 0.
  - out_last = buf_valid & (idx == RP-1).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable every cycle.
- Flush has priority over everything:
  - Next cycle buf_valid=0, idx=0.
  - fifo_pop=0 in the flush cycle, even if a final accept occurs then.
  - A lane accepted in the flush cycle counts as delivered; the rest of the row is dropped.
- RP=1:
  - idx stays 0 and out_last = out_valid.
  - The block degenerates to a one-entry skid register.
- Reset mid-row: everything returns to the reset values immediately; partially sent row discarded.
- Arithmetic: idx increments modulo RP only through the rules above; idx never exceeds RP-1.

Test Plan (DW=8, RP=4 unless stated):
- Reset, fifo_empty=1, out_ready=1 -> out_valid=0, fifo_pop=0, out_data=0x00 for 5 cycles after RSTn rises.
- One row data_r=0x44332211, fifo_empty low for one cycle, out_ready=1:
  - fifo_pop=1 in cycle 0 only.
  - out_data 0x11,0x22,0x33,0x44 in cycles 1-4.
  - out_last=1 only with 0x44; out_valid=0 in cycle 5.
- Two rows 0x44332211 then 0x88776655 queued, out_ready=1:
  - Second fifo_pop coincides with the accept of 0x44.
  - 8 lanes on consecutive cycles 1-8 with no gap.
  - out_last in cycles 4 and 8.
- Backpressure: out_ready=0 for 3 cycles while 0x22 is shown -> out_data holds 0x22, no pop; stream resumes 0x33,0x44 when ready returns.
- Flush after 0x22 accepted, fifo_empty=0 in the flush cycle:
  - fifo_pop=0 in the flush cycle; out_valid=0 the next cycle.
  - The next pop starts at lane 0 of the new row.
- RP=1, DW=8, rows 0xA5,0x5A with out_ready toggling 1,0,1 -> each lane has out_last=1, 0x5A held during the stall, exactly two pops.
